// File: rtl/retire_map_free.sv
// Retirement-side rename bookkeeping.
// Commits up to N ROB-head instructions per cycle into the architectural map.
// Returns each overwritten mapping (Told) to the free list.
// Raises a one-cycle recovery pulse when a mispredicted branch retires.
module retire_map_free #(
    parameter int N             = 3,
    parameter int ARCH_REGS     = 32,
    parameter int PHYS_REGS     = 64,
    parameter int PHYS_REG_BITS = $clog2(PHYS_REGS),
    parameter int ARCH_REG_BITS = $clog2(ARCH_REGS)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [N-1:0]                              retire_valid,
    input  logic [N-1:0]                              retire_has_dest,
    input  logic [N-1:0][ARCH_REG_BITS-1:0]           retire_arch_reg,
    input  logic [N-1:0][PHYS_REG_BITS-1:0]           retire_new_preg,
    input  logic [N-1:0]                              retire_mispredict,
    output logic [N-1:0]                              free_reg_request,
    output logic [N-1:0][PHYS_REG_BITS-1:0]           enqueue_preg,
    output logic                                      branch_mispredict,
    output logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0]   arch_map_mispredict_input,
    output logic [31:0]                               retired_count
);

    localparam int CNT_BITS = $clog2(N + 1);

    logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0] map_next;
    logic [N-1:0]                            req_next;
    logic [N-1:0][PHYS_REG_BITS-1:0]         told_next;
    logic                                    mp_next;
    logic [CNT_BITS-1:0]                     eff_count;
    logic                                    alive;

    // Walk the slots oldest-first, forwarding map updates to younger slots
    // and stopping at the first invalid slot or after a mispredicted branch.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves a value held and no latch is inferred.
        map_next  = arch_map_mispredict_input;
        req_next  = '0;
        told_next = '0;
        mp_next   = 1'b0;
        eff_count = '0;
        alive     = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (alive && retire_valid[i]) begin
                eff_count = eff_count + CNT_BITS'(1);
                if (retire_has_dest[i] && (retire_arch_reg[i] != '0)) begin
                    req_next[i]                 = 1'b1;
                    told_next[i]                = map_next[retire_arch_reg[i]];
                    map_next[retire_arch_reg[i]] = retire_new_preg[i];
                end
                if (retire_mispredict[i]) begin
                    mp_next = 1'b1;
                    alive   = 1'b0;
                end
            end else begin
                alive = 1'b0;
            end
        end
    end

    // Register the committed map, the free requests, the pulse and the counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the map is a real reset target, not scratch storage: the
            // identity mapping is what the free list assumes it does not own.
            for (int i = 0; i < ARCH_REGS; i++) begin
                arch_map_mispredict_input[i] <= PHYS_REG_BITS'(i);
            end
            free_reg_request  <= '0;
            enqueue_preg      <= '0;
            branch_mispredict <= 1'b0;
            retired_count     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others.
            arch_map_mispredict_input <= map_next;
            free_reg_request          <= req_next;
            enqueue_preg              <= told_next;
            branch_mispredict         <= mp_next;
            retired_count             <= retired_count + 32'(eff_count);
        end
    end

endmodule

// File: tb/tb_retire_map_free.sv
// Self-checking bench for retire_map_free: directed steps, then randomized
// retirement groups checked against an array/queue reference model.
module tb_retire_map_free;

    localparam int N  = 3;
    localparam int AR = 32;
    localparam int PR = 64;
    localparam int PB = 6;
    localparam int AB = 5;

    logic                     clock;
    logic                     reset;
    logic [N-1:0]             retire_valid;
    logic [N-1:0]             retire_has_dest;
    logic [N-1:0][AB-1:0]     retire_arch_reg;
    logic [N-1:0][PB-1:0]     retire_new_preg;
    logic [N-1:0]             retire_mispredict;
    logic [N-1:0]             free_reg_request;
    logic [N-1:0][PB-1:0]     enqueue_preg;
    logic                     branch_mispredict;
    logic [AR-1:0][PB-1:0]    arch_map_mispredict_input;
    logic [31:0]              retired_count;

    retire_map_free #(.N(N), .ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .retire_valid              (retire_valid),
        .retire_has_dest           (retire_has_dest),
        .retire_arch_reg           (retire_arch_reg),
        .retire_new_preg           (retire_new_preg),
        .retire_mispredict         (retire_mispredict),
        .free_reg_request          (free_reg_request),
        .enqueue_preg              (enqueue_preg),
        .branch_mispredict         (branch_mispredict),
        .arch_map_mispredict_input (arch_map_mispredict_input),
        .retired_count             (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    int          mmap [AR];
    int unsigned mcount;
    bit          exp_req [N];
    int          exp_enq [N];
    bit          exp_mp;
    int          fq [$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < AR; i++) mmap[i] = i;
        mcount = 0;
        exp_mp = 0;
        for (int i = 0; i < N; i++) begin
            exp_req[i] = 0;
            exp_enq[i] = 0;
        end
    endtask

    // Apply the retirement rules to the inputs currently being driven.
    task automatic model_cycle();
        exp_mp = 0;
        for (int i = 0; i < N; i++) begin
            exp_req[i] = 0;
            exp_enq[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (!retire_valid[i]) break;
            mcount++;
            if (retire_has_dest[i] && retire_arch_reg[i] != 0) begin
                exp_req[i] = 1;
                exp_enq[i] = mmap[retire_arch_reg[i]];
                mmap[retire_arch_reg[i]] = retire_new_preg[i];
            end
            if (retire_mispredict[i]) begin
                exp_mp = 1;
                break;
            end
        end
    endtask

    task automatic check_outputs();
        int dups;
        int in_map;
        for (int i = 0; i < N; i++) begin
            check($sformatf("free_req[%0d]", i), free_reg_request[i], exp_req[i]);
            check($sformatf("enq_preg[%0d]", i), enqueue_preg[i], exp_enq[i]);
        end
        check("branch_mispredict", branch_mispredict, exp_mp);
        check("retired_count", retired_count, mcount);
        for (int i = 0; i < AR; i++)
            check($sformatf("arch_map[%0d]", i), arch_map_mispredict_input[i], mmap[i]);
        dups = 0;
        for (int i = 0; i < AR; i++)
            for (int j = i + 1; j < AR; j++)
                if (arch_map_mispredict_input[i] == arch_map_mispredict_input[j]) dups++;
        check("map_duplicates", dups, 0);
        in_map = 0;
        for (int i = 0; i < N; i++)
            if (free_reg_request[i])
                for (int k = 0; k < AR; k++)
                    if (arch_map_mispredict_input[k] == enqueue_preg[i]) in_map++;
        check("told_in_map", in_map, 0);
    endtask

    task automatic clear_inputs();
        retire_valid      = '0;
        retire_has_dest   = '0;
        retire_arch_reg   = '0;
        retire_new_preg   = '0;
        retire_mispredict = '0;
    endtask

    task automatic set_slot(input int i, input bit v, input bit d, input int a, input int p, input bit m);
        retire_valid[i]      = v;
        retire_has_dest[i]   = d;
        retire_arch_reg[i]   = AB'(a);
        retire_new_preg[i]   = PB'(p);
        retire_mispredict[i] = m;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clock);
        #1;
        check_outputs();
        clear_inputs();
    endtask

    initial begin
        bit alive;
        bit eff;
        clear_inputs();
        reset = 1'b0;
        model_reset();
        #12;
        check_outputs();                 // reset state while held
        reset = 1'b1;
        step();                          // idle cycle after release

        // Single retirement: r3 -> p40, Told = 3
        set_slot(0, 1, 1, 3, 40, 0);
        step();

        // Same-cycle collision on r7
        set_slot(0, 1, 1, 7, 33, 0);
        set_slot(1, 1, 1, 7, 34, 0);
        set_slot(2, 1, 1, 7, 35, 0);
        step();

        // Contiguity: valid=101, only slot 0 effective
        set_slot(0, 1, 1, 8, 41, 0);
        set_slot(2, 1, 1, 9, 42, 0);
        step();

        // r0 destination: counted, no free, no map change
        set_slot(0, 1, 1, 0, 50, 0);
        step();

        // Mispredict in slot 1; slot 2 is wrong-path
        set_slot(0, 1, 1, 6, 47, 0);
        set_slot(1, 1, 1, 4, 45, 1);
        set_slot(2, 1, 1, 5, 46, 0);
        step();
        step();                          // pulse lasts exactly one cycle

        // Back-to-back mispredicts
        set_slot(0, 1, 0, 0, 0, 1);
        step();
        set_slot(0, 1, 1, 10, 48, 1);
        step();

        // Reset mid-stream with outputs pending
        set_slot(0, 1, 1, 11, 49, 0);
        set_slot(1, 1, 1, 12, 51, 0);
        set_slot(2, 1, 1, 13, 52, 0);
        model_cycle();
        @(posedge clock);
        #1;
        clear_inputs();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        reset = 1'b1;

        // Randomized groups: 15 full 3-wide cycles, then mixed patterns
        for (int p = AR; p < PR; p++) fq.push_back(p);
        for (int c = 0; c < 40; c++) begin
            alive = 1;
            for (int i = 0; i < N; i++) begin
                bit v, d, m;
                if (c < 15) begin
                    v = 1; d = 1; m = 0;
                end else begin
                    v = ($urandom_range(0, 4) != 0);
                    d = ($urandom_range(0, 3) != 0);
                    m = ($urandom_range(0, 5) == 0);
                end
                eff = alive && v;
                if (eff && d)
                    set_slot(i, v, d, $urandom_range(1, AR - 1), fq.pop_front(), m);
                else
                    set_slot(i, v, d, $urandom_range(0, AR - 1), $urandom_range(0, PR - 1), m);
                if (!eff || m) alive = 0;
            end
            step();
            for (int i = 0; i < N; i++)
                if (exp_req[i]) fq.push_back(exp_enq[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
